// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlyline_prog.sv
// Programmable clock-enabled delay line with fill/valid tracking.
// Delays a WIDTH-bit bus by 1..DEPTH enabled cycles, chosen at run time by SEL.
// Optional feature: define DLYLINE_BYPASS_EN to make SEL=0 a zero-cycle
// transparent path (Z=I, VLD=1).
module gf180mcu_fd_sc_mcu7t5v0__dlyline_prog #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SELW  = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             FLUSH,
  input  logic [SELW-1:0]  SEL,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Z,
  output logic             VLD,
  output logic             SEL_ERR
);

  localparam logic [SELW-1:0] DEPTH_S = SELW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] stage;
  logic [SELW-1:0]             fill;
  logic [SELW-1:0]             sel_eff;
  logic                        sel_zero;
  logic                        sel_over;
  logic [WIDTH-1:0]            tap;

  // Shift register: stage[0] takes I, every stage moves up on enabled edges.
  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      stage <= '0;
    end else if (EN) begin
      stage <= {stage[DEPTH-2:0], I};
    end
  end

  // Count of genuine samples in the line, saturating at DEPTH.
  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      fill <= '0;
    end else if (EN && (fill != DEPTH_S)) begin
      fill <= fill + SELW'(1);
    end
  end

  // Clamp the requested delay into 1..DEPTH.
  always_comb begin
    sel_zero = (SEL == '0);
    sel_over = (SEL > DEPTH_S);
    sel_eff  = SEL;
    if (sel_zero) begin
      sel_eff = SELW'(1);
    end else if (sel_over) begin
      sel_eff = DEPTH_S;
    end
  end

  // Tap mux written as a compare chain so no index can fall outside stage[].
  always_comb begin
    tap = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (sel_eff == SELW'(k + 1)) begin
        tap = stage[k];
      end
    end
  end

  // Output selection, valid flag and range error.
  always_comb begin
    Z       = tap;
    VLD     = (fill >= sel_eff);
`ifdef DLYLINE_BYPASS_EN
    SEL_ERR = sel_over;
    if (sel_zero) begin
      Z   = I;
      VLD = 1'b1;
    end
`else
    SEL_ERR = sel_over || sel_zero;
`endif
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dlyline_prog.sv
// Scoreboard bench for the programmable delay line (WIDTH=8, DEPTH=8).
// The reference model keeps the list of genuine samples since the last clear.
module tb_gf180mcu_fd_sc_mcu7t5v0__dlyline_prog;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned SELW  = $clog2(DEPTH + 1);

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             EN = 1'b0;
  logic             FLUSH = 1'b0;
  logic [SELW-1:0]  SEL = '0;
  logic [WIDTH-1:0] I = '0;
  logic [WIDTH-1:0] Z;
  logic             VLD;
  logic             SEL_ERR;

  gf180mcu_fd_sc_mcu7t5v0__dlyline_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .FLUSH(FLUSH), .SEL(SEL), .I(I),
    .Z(Z), .VLD(VLD), .SEL_ERR(SEL_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [WIDTH-1:0] z;
    logic             vld;
    logic             err;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] hist[$];   // newest sample at index 0
  int               total = 0;
  int               bad = 0;
  bit               checking = 1'b0;

  // One cycle of stimulus: apply inputs, predict outputs, then advance model.
  task automatic drive(input bit rst, input bit flush, input bit en,
                       input int sel, input logic [WIDTH-1:0] din);
    exp_t e;
    int   eff;
    RST = rst; FLUSH = flush; EN = en; SEL = SELW'(sel); I = din;
    eff = (sel == 0) ? 1 : ((sel > DEPTH) ? DEPTH : sel);
    e.z   = (hist.size() >= eff) ? hist[eff-1] : '0;
    e.vld = (hist.size() >= eff);
    e.err = (sel > DEPTH) || (sel == 0);
`ifdef DLYLINE_BYPASS_EN
    if (sel == 0) begin
      e.z = din; e.vld = 1'b1; e.err = 1'b0;
    end
`endif
    if (checking) sb.push_back(e);
    @(posedge CLK);
    if (rst || flush) begin
      hist.delete();
    end else if (en) begin
      hist.push_front(din);
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
    #1;
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (Z !== e.z) begin
        bad++;
        $display("FAIL z @%0t: got %h want %h (sel=%0d)", $time, Z, e.z, SEL);
      end
      total++;
      if (VLD !== e.vld) begin
        bad++;
        $display("FAIL vld @%0t: got %b want %b (sel=%0d)", $time, VLD, e.vld, SEL);
      end
      total++;
      if (SEL_ERR !== e.err) begin
        bad++;
        $display("FAIL sel_err @%0t: got %b want %b (sel=%0d)", $time, SEL_ERR, e.err, SEL);
      end
    end
  end

  initial begin
    @(posedge CLK); #1;
    // Initial reset establishes known contents before checking starts.
    drive(1, 0, 0, 3, 8'h00);
    checking = 1'b1;
    drive(1, 0, 0, 3, 8'h00);

    // Reset/latency with SEL=3 and an incrementing ramp.
    for (int k = 1; k <= 12; k++) drive(0, 0, 1, 3, 8'(k));

    // EN stall with a full line at SEL=4.
    for (int k = 13; k <= 20; k++) drive(0, 0, 1, 4, 8'(k));
    for (int k = 0; k < 5; k++) drive(0, 0, 0, 4, 8'($urandom));
    for (int k = 21; k <= 28; k++) drive(0, 0, 1, 4, 8'(k));

    // Live SEL change from 2 to 6 after 8 enabled cycles.
    drive(0, 1, 1, 2, 8'hEE);
    for (int k = 1; k <= 8; k++) drive(0, 0, 1, 2, 8'(k));
    for (int k = 9; k <= 12; k++) drive(0, 0, 1, 6, 8'(k));

    // Flush mid-flight at SEL=5.
    drive(1, 0, 0, 5, 8'h00);
    for (int k = 1; k <= 3; k++) drive(0, 0, 1, 5, 8'(8'h40 + k));
    drive(0, 1, 1, 5, 8'h99);
    for (int k = 1; k <= 8; k++) drive(0, 0, 1, 5, 8'(8'h50 + k));

    // Range and clamp: SEL above DEPTH, then SEL=0.
    for (int k = 0; k < 10; k++) drive(0, 0, 1, 12, 8'($urandom));
    for (int k = 0; k < 10; k++) drive(0, 0, 1, 8, 8'($urandom));
    for (int k = 0; k < 5; k++) drive(0, 0, 1, 0, 8'($urandom));
    for (int k = 0; k < 3; k++) drive(0, 0, 1, 4, 8'($urandom));

    // Priority: all controls together, then reset alone.
    drive(1, 1, 1, 1, 8'hAA);
    for (int k = 0; k < 3; k++) drive(0, 0, 1, 1, 8'($urandom));
    drive(1, 0, 1, 1, 8'hBB);
    drive(0, 0, 0, 1, 8'hCC);

    // Fill saturation: long enabled run at maximum delay.
    for (int k = 0; k < 100; k++) drive(0, 0, 1, 8, 8'($urandom));

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
            8'($urandom));
    end

    drive(0, 0, 0, 1, 8'h00);
    repeat (3) @(negedge CLK);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
